// File: rtl/pe_result_dispatch_pkg.sv
// Shared constants for the PE result dispatch stage: destination indices and retire accounting.
package pe_result_dispatch_pkg;

    localparam int DEST_NS  = 0;
    localparam int DEST_NB  = 1;
    localparam int DEST_PU  = 2;
    localparam int DEST_GB  = 3;
    localparam int NUM_DEST = 4;

    // A zero-mask drop and a head pop may land on the same edge.
    function automatic logic [1:0] retireCount(input logic dropRetire, input logic headRetire);
        return {1'b0, dropRetire} + {1'b0, headRetire};
    endfunction

endpackage

// File: rtl/dispatch_fifo.sv
// First-word-fall-through FIFO holding {eol, mask, data} entries for the dispatch stage.
module dispatch_fifo #(
    parameter int width = 37,
    parameter int depth = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wrEn,
    input  logic [width-1:0] wrData,
    input  logic             rdEn,
    output logic [width-1:0] rdData,
    output logic             full,
    output logic             empty
);
    localparam int ptrLen = $clog2(depth);

    // Extra MSB on each pointer separates full from empty when the indices match.
    logic [ptrLen:0]    wrPtr;
    logic [ptrLen:0]    rdPtr;
    logic [width-1:0]   mem [depth];

    always_ff @(posedge clk) begin
        if (reset) begin
            wrPtr <= '0;
            rdPtr <= '0;
        end else begin
            if (wrEn) wrPtr <= wrPtr + (ptrLen+1)'(1);
            if (rdEn) rdPtr <= rdPtr + (ptrLen+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (wrEn) mem[wrPtr[ptrLen-1:0]] <= wrData;
    end

    assign rdData = mem[rdPtr[ptrLen-1:0]];
    assign empty  = (wrPtr == rdPtr);
    assign full   = (wrPtr[ptrLen] != rdPtr[ptrLen]) &&
                    (wrPtr[ptrLen-1:0] == rdPtr[ptrLen-1:0]);

endmodule

// File: rtl/pe_result_dispatch.sv
// Buffers completed PE results and delivers each to every selected consumer by valid/ready.
// Handshake: a destination transfer happens on any edge where dest_v[i] and dest_rdy[i] are both high.
module pe_result_dispatch
    import pe_result_dispatch_pkg::*;
#(
    parameter int dataLen = 32,
    parameter int numDest = NUM_DEST,
    parameter int depth   = 2,
    parameter int cntLen  = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [dataLen-1:0] result_in,
    input  logic               result_v,
    input  logic               eol_in,
    input  logic [numDest-1:0] dest_mask,
    output logic               ready_in,
    output logic [dataLen-1:0] data_out,
    output logic [numDest-1:0] dest_v,
    input  logic [numDest-1:0] dest_rdy,
    output logic               eol_out,
    output logic [cntLen-1:0]  retired_cnt
);
    localparam int entryLen = dataLen + numDest + 1;

    logic                accept;
    logic                dropZero;
    logic                push;
    logic                pop;
    logic                full;
    logic                empty;
    logic                headValid;
    logic [entryLen-1:0] headEntry;
    logic [dataLen-1:0]  headData;
    logic [numDest-1:0]  headMask;
    logic                headEol;
    logic [numDest-1:0]  doneMask;
    logic [numDest-1:0]  pending;
    logic [numDest-1:0]  handshake;

    assign ready_in = !reset && !full;
    assign accept   = result_v && ready_in;
    assign dropZero = accept && (dest_mask == '0);
    assign push     = accept && (dest_mask != '0);

    dispatch_fifo #(
        .width (entryLen),
        .depth (depth)
    ) u_fifo (
        .clk    (clk),
        .reset  (reset),
        .wrEn   (push),
        .wrData ({eol_in, dest_mask, result_in}),
        .rdEn   (pop),
        .rdData (headEntry),
        .full   (full),
        .empty  (empty)
    );

    assign headValid = !empty;
    assign {headEol, headMask, headData} = headEntry;

    // Tracking completed destinations (rather than remaining ones) lets a fresh head
    // present its full mask without copying it out of the FIFO.
    assign pending   = headMask & ~doneMask;
    assign dest_v    = headValid ? pending : '0;
    assign data_out  = headValid ? headData : '0;
    assign handshake = dest_v & dest_rdy;
    assign pop       = headValid && ((pending & ~dest_rdy) == '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            doneMask    <= '0;
            eol_out     <= 1'b0;
            retired_cnt <= '0;
        end else begin
            doneMask    <= pop ? '0 : (doneMask | handshake);
            eol_out     <= (dropZero && eol_in) || (pop && headEol);
            retired_cnt <= retired_cnt + cntLen'(retireCount(dropZero, pop));
        end
    end

endmodule

// File: tb/tb_pe_result_dispatch.sv
// Randomised and directed bench for pe_result_dispatch against a queue-based reference model.
module tb_pe_result_dispatch;
    localparam int DATA  = 32;
    localparam int NDEST = 4;
    localparam int DEPTH = 2;
    localparam int CNTW  = 4;

    logic             clk = 1'b0;
    logic             reset;
    logic [DATA-1:0]  result_in;
    logic             result_v;
    logic             eol_in;
    logic [NDEST-1:0] dest_mask;
    logic             ready_in;
    logic [DATA-1:0]  data_out;
    logic [NDEST-1:0] dest_v;
    logic [NDEST-1:0] dest_rdy;
    logic             eol_out;
    logic [CNTW-1:0]  retired_cnt;

    pe_result_dispatch #(
        .dataLen (DATA),
        .numDest (NDEST),
        .depth   (DEPTH),
        .cntLen  (CNTW)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .result_in   (result_in),
        .result_v    (result_v),
        .eol_in      (eol_in),
        .dest_mask   (dest_mask),
        .ready_in    (ready_in),
        .data_out    (data_out),
        .dest_v      (dest_v),
        .dest_rdy    (dest_rdy),
        .eol_out     (eol_out),
        .retired_cnt (retired_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [DATA-1:0]  data;
        logic [NDEST-1:0] mask;
        logic             eol;
    } entry_t;

    // Reference state: queue of buffered results, remaining mask of the head, counters.
    entry_t           expQ[$];
    logic [NDEST-1:0] modelPending;
    int               modelCnt;
    logic             modelEol;
    int               checks   = 0;
    int               failures = 0;

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    // One clock: drive inputs, compare outputs against the model, then advance the model.
    task automatic step(input logic rs, input logic rv, input logic [DATA-1:0] d,
                        input logic e, input logic [NDEST-1:0] m, input logic [NDEST-1:0] r);
        int   retires;
        logic eolNext;
        logic canAccept;
        logic headChanged;
        @(negedge clk);
        reset     = rs;
        result_v  = rv;
        result_in = d;
        eol_in    = e;
        dest_mask = m;
        dest_rdy  = r;
        #1;
        checkVal("ready_in", 32'(ready_in), 32'(!rs && (expQ.size() < DEPTH)));
        checkVal("dest_v", 32'(dest_v), (expQ.size() > 0) ? 32'(modelPending) : 32'd0);
        checkVal("data_out", data_out, (expQ.size() > 0) ? expQ[0].data : 32'd0);
        checkVal("eol_out", 32'(eol_out), 32'(modelEol));
        checkVal("retired_cnt", 32'(retired_cnt), 32'(modelCnt));
        @(posedge clk);
        if (rs) begin
            expQ.delete();
            modelPending = '0;
            modelCnt     = 0;
            modelEol     = 1'b0;
            return;
        end
        retires     = 0;
        eolNext     = 1'b0;
        headChanged = 1'b0;
        canAccept   = (expQ.size() < DEPTH);
        if (expQ.size() > 0) begin
            modelPending = modelPending & ~r;
            if (modelPending == '0) begin
                eolNext |= expQ[0].eol;
                void'(expQ.pop_front());
                retires++;
                headChanged = 1'b1;
            end
        end else begin
            headChanged = 1'b1;
        end
        if (rv && canAccept) begin
            if (m == '0) begin
                retires++;
                eolNext |= e;
            end else begin
                expQ.push_back('{data: d, mask: m, eol: e});
            end
        end
        if (headChanged && expQ.size() > 0) modelPending = expQ[0].mask;
        modelCnt = (modelCnt + retires) % (1 << CNTW);
        modelEol = eolNext;
    endtask

    task automatic idle(input logic [NDEST-1:0] r, input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, '0, 1'b0, '0, r);
    endtask

    function automatic logic [NDEST-1:0] randRdy();
        logic [NDEST-1:0] r;
        for (int i = 0; i < NDEST; i++) r[i] = ($urandom_range(0, 9) < 7);
        return r;
    endfunction

    initial begin
        reset     = 1'b1;
        result_v  = 1'b0;
        result_in = '0;
        eol_in    = 1'b0;
        dest_mask = '0;
        dest_rdy  = '0;
        expQ.delete();
        modelPending = '0;
        modelCnt     = 0;
        modelEol     = 1'b0;
        @(posedge clk);
        step(1'b1, 1'b0, '0, 1'b0, '0, '0);

        // Single result to two destinations, all ready.
        step(1'b0, 1'b1, 32'h1234, 1'b0, 4'b0101, 4'b1111);
        idle(4'b1111, 2);

        // Split delivery: destination 0 first, the rest three cycles later.
        step(1'b0, 1'b1, 32'h1234, 1'b0, 4'b1111, 4'b0000);
        step(1'b0, 1'b0, '0, 1'b0, '0, 4'b0001);
        idle(4'b0000, 2);
        step(1'b0, 1'b0, '0, 1'b0, '0, 4'b1110);
        idle(4'b0000, 1);

        // Backpressure: third result is refused until the buffer drains.
        step(1'b0, 1'b1, 32'hAAAA_0001, 1'b0, 4'b0011, 4'b0000);
        step(1'b0, 1'b1, 32'hBBBB_0002, 1'b1, 4'b1000, 4'b0000);
        step(1'b0, 1'b1, 32'hCCCC_0003, 1'b0, 4'b0100, 4'b0000);
        step(1'b0, 1'b1, 32'hCCCC_0003, 1'b0, 4'b0100, 4'b1111);
        step(1'b0, 1'b1, 32'hCCCC_0003, 1'b0, 4'b0100, 4'b1111);
        idle(4'b1111, 3);

        // Zero-mask eol drop alone, then sharing an edge with a head retire.
        step(1'b0, 1'b1, 32'h0, 1'b1, 4'b0000, 4'b1111);
        idle(4'b1111, 1);
        step(1'b0, 1'b1, 32'h5555, 1'b0, 4'b0010, 4'b0000);
        step(1'b0, 1'b1, 32'h6666, 1'b1, 4'b0000, 4'b0010);
        idle(4'b1111, 2);

        // Reset while two entries are waiting.
        step(1'b0, 1'b1, 32'h7777, 1'b0, 4'b0010, 4'b0000);
        step(1'b0, 1'b1, 32'h8888, 1'b0, 4'b0010, 4'b0000);
        step(1'b1, 1'b0, '0, 1'b0, '0, 4'b0000);
        idle(4'b1111, 2);

        // Counter wrap through back-to-back zero-mask drops.
        for (int i = 0; i < (1 << CNTW) + 1; i++) step(1'b0, 1'b1, '0, 1'b0, '0, 4'b1111);
        idle(4'b1111, 1);

        // Randomised traffic with occasional reset.
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 199) == 0), ($urandom_range(0, 3) != 0), $urandom(),
                 ($urandom_range(0, 3) == 0), 4'($urandom_range(0, 15)), randRdy());
        end
        idle(4'b1111, 4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
